// File: rtl/ccip_arb_pkg.sv
// Shared CCI-P c1 write-path types, state encoding and header builders.
// Used by ccip_c1_wr_arbiter and reusable by the c0 read-path arbiter.
package ccip_arb_pkg;

  localparam int CL_ADDR_W = 42;
  localparam int CL_DATA_W = 512;
  localparam int MDATA_W   = 16;

  typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;
  typedef logic [MDATA_W-1:0]   t_ccip_mdata;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h1,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef enum logic [1:0] {
    ARB        = 2'd0,
    DRAIN      = 2'd1,
    FENCE      = 2'd2,
    FENCE_WAIT = 2'd3
  } t_wr_arb_state;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  function automatic t_ccip_c1_ReqMemHdr build_wrline_hdr(input t_ccip_clAddr addr,
                                                          input t_ccip_mdata  mdata);
    t_ccip_c1_ReqMemHdr h;
    h          = '0;
    h.vc_sel   = eVC_VA;
    h.sop      = 1'b1;
    h.cl_len   = eCL_LEN_1;
    h.req_type = eREQ_WRLINE_I;
    h.address  = addr;
    h.mdata    = mdata;
    return h;
  endfunction

  function automatic t_ccip_c1_ReqMemHdr build_wrfence_hdr();
    t_ccip_c1_ReqMemHdr h;
    h          = '0;
    h.vc_sel   = eVC_VA;
    h.req_type = eREQ_WRFENCE;
    return h;
  endfunction

endpackage

// File: rtl/ccip_c1_wr_arbiter_if.sv
// Requester-side and CCI-P c1 bus bundle for ccip_c1_wr_arbiter.
// slave = the arbiter, master = the environment driving requests and responses.
interface ccip_c1_wr_arbiter_if
  import ccip_arb_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int MAX_OUTSTANDING = 64
) ();
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                         c1TxAlmFull;
  t_ccip_c1_RspMemHdr           c1Rx_hdr;
  logic                         c1Rx_rspValid;
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ*CL_ADDR_W-1:0]   req_addr;
  logic [N_REQ*CL_DATA_W-1:0]   req_data;
  t_ccip_c1_ReqMemHdr           c1Tx_hdr;
  logic [CL_DATA_W-1:0]         c1Tx_data;
  logic                         c1Tx_valid;
  logic [N_REQ-1:0]             wr_done;
  logic [OUT_W-1:0]             outstanding;
  logic                         idle;

  modport slave (
    input  c1TxAlmFull, c1Rx_hdr, c1Rx_rspValid, req_valid, req_addr, req_data,
    output req_ready, c1Tx_hdr, c1Tx_data, c1Tx_valid, wr_done, outstanding, idle
  );

  modport master (
    output c1TxAlmFull, c1Rx_hdr, c1Rx_rspValid, req_valid, req_addr, req_data,
    input  req_ready, c1Tx_hdr, c1Tx_data, c1Tx_valid, wr_done, outstanding, idle
  );
endinterface

// File: rtl/ccip_c1_wr_arbiter_rr_arbiter.sv
// Round-robin picker: grants the first request at or after ptr, wrapping.
// Purely combinational so it can also serve the c0 read path.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // Rotating priority search starting at ptr.
  always_comb begin
    gnt = {N{1'b0}};
    idx = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      int  j;
      j = int'(ptr) + i;
      j = (j >= N) ? (j - N) : j;
      if ((gnt == {N{1'b0}}) && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end else begin
        gnt = gnt;
      end
    end
  end
endmodule

// File: rtl/ccip_c1_wr_arbiter.sv
// Round-robin c1 WrLine arbiter with almost-full and credit back-pressure.
// Optional drain/WrFence sequencer enabled by defining CCIP_C1_WR_FENCE_EN.
module ccip_c1_wr_arbiter
  import ccip_arb_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                  pClk,
  input  logic                  pck_cp2af_softReset,
  ccip_c1_wr_arbiter_if.slave   bus
`ifdef CCIP_C1_WR_FENCE_EN
  ,
  input  logic                  drain_req,
  output logic                  drain_done
`endif
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int SEQ_W = MDATA_W - ID_W;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [OUT_W-1:0]   outstanding_q, outstanding_d;
  logic               c1tx_valid_q, c1tx_valid_d;
  t_ccip_c1_ReqMemHdr c1tx_hdr_q, c1tx_hdr_d;
  logic [CL_DATA_W-1:0] c1tx_data_q, c1tx_data_d;
  logic [N_REQ-1:0]   wr_done_q, wr_done_d;

  logic [N_REQ-1:0]   arb_gnt_s;
  logic [ID_W-1:0]    arb_idx_s;
  logic               arb_en_s, fence_issue_s, can_issue_s, issue_s, rsp_take_s;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_rr (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s)
  );

`ifdef CCIP_C1_WR_FENCE_EN
  t_wr_arb_state state_q;
  logic          drain_done_q;

  assign arb_en_s      = (state_q == ARB);
  assign fence_issue_s = (state_q == FENCE) && !bus.c1TxAlmFull;
  assign drain_done    = drain_done_q;

  // Drain/fence sequencer; fence responses only advance this FSM.
  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      state_q      <= ARB;
      drain_done_q <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      case (state_q)
        ARB:        if (drain_req) state_q <= DRAIN;
        DRAIN:      if (outstanding_q == {OUT_W{1'b0}}) state_q <= FENCE;
        FENCE:      if (!bus.c1TxAlmFull) state_q <= FENCE_WAIT;
        FENCE_WAIT: if (bus.c1Rx_rspValid && (bus.c1Rx_hdr.resp_type == eRSP_WRFENCE)) begin
                      drain_done_q <= 1'b1;
                      state_q      <= ARB;
                    end
        default:    state_q <= ARB;
      endcase
    end
  end
`else
  assign arb_en_s      = 1'b1;
  assign fence_issue_s = 1'b0;
`endif

  // Grant qualification, credit accounting and Tx staging.
  always_comb begin
    can_issue_s   = arb_en_s && !bus.c1TxAlmFull && !pck_cp2af_softReset &&
                    (outstanding_q < OUT_W'(MAX_OUTSTANDING));
    bus.req_ready = can_issue_s ? arb_gnt_s : {N_REQ{1'b0}};
    issue_s       = can_issue_s && (|arb_gnt_s);
    // A response with nothing outstanding is a leftover from before reset.
    rsp_take_s    = bus.c1Rx_rspValid && (bus.c1Rx_hdr.resp_type == eRSP_WRLINE) &&
                    (outstanding_q != {OUT_W{1'b0}});

    rr_ptr_d = rr_ptr_q;
    seq_d    = seq_q;
    if (issue_s) begin
      rr_ptr_d = (arb_idx_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : (arb_idx_s + ID_W'(1));
      seq_d    = seq_q + SEQ_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
      seq_d    = seq_q;
    end

    case ({issue_s, rsp_take_s})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    wr_done_d = rsp_take_s ? (N_REQ'(1) << bus.c1Rx_hdr.mdata[ID_W-1:0]) : {N_REQ{1'b0}};

    c1tx_valid_d = issue_s || fence_issue_s;
    if (issue_s) begin
      c1tx_hdr_d  = build_wrline_hdr(bus.req_addr[int'(arb_idx_s)*CL_ADDR_W +: CL_ADDR_W],
                                     {seq_q, arb_idx_s});
      c1tx_data_d = bus.req_data[int'(arb_idx_s)*CL_DATA_W +: CL_DATA_W];
    end else if (fence_issue_s) begin
      c1tx_hdr_d  = build_wrfence_hdr();
      c1tx_data_d = {CL_DATA_W{1'b0}};
    end else begin
      c1tx_hdr_d  = '0;
      c1tx_data_d = {CL_DATA_W{1'b0}};
    end
  end

  // Datapath and bookkeeping registers.
  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      rr_ptr_q      <= {ID_W{1'b0}};
      seq_q         <= {SEQ_W{1'b0}};
      outstanding_q <= {OUT_W{1'b0}};
      c1tx_valid_q  <= 1'b0;
      c1tx_hdr_q    <= '0;
      c1tx_data_q   <= {CL_DATA_W{1'b0}};
      wr_done_q     <= {N_REQ{1'b0}};
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      seq_q         <= seq_d;
      outstanding_q <= outstanding_d;
      c1tx_valid_q  <= c1tx_valid_d;
      c1tx_hdr_q    <= c1tx_hdr_d;
      c1tx_data_q   <= c1tx_data_d;
      wr_done_q     <= wr_done_d;
    end
  end

  assign bus.c1Tx_valid  = c1tx_valid_q;
  assign bus.c1Tx_hdr    = c1tx_hdr_q;
  assign bus.c1Tx_data   = c1tx_data_q;
  assign bus.wr_done     = wr_done_q;
  assign bus.outstanding = outstanding_q;
  assign bus.idle        = (outstanding_q == {OUT_W{1'b0}}) && !issue_s && !c1tx_valid_q;

endmodule
